ldm_stm_seq: RTL and testbench
==============================

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 Parameter ADDR_STEP, default 4: byte increment applied to the transfer address after each register.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a block transfer; sampled only in IDLE.
REQ-005 is_load  input  1  1 = LDM (memory to registers), 0 = STM (registers to memory); latched at start.
REQ-006 reglist  input  16  register mask, bit i = Ri; latched at start.
REQ-007 base  input  32  first transfer address; latched at start.
REQ-008 mem_addr  output  32  current transfer address.
REQ-009 mem_we  output  1  memory write request (STM).
REQ-010 mem_re  output  1  memory read request (LDM).
REQ-011 mem_wdata  output  32  store data, equal to rf_rd.
REQ-012 mem_rdata  input  32  load data, valid in the mem_ack cycle.
REQ-013 mem_ack  input  1  memory completes the request in this cycle; zero-wait (same-cycle) ack is legal.
REQ-014 rf_ra  output  4  register file read address (STM source).
REQ-015 rf_rd  input  32  register file read data for rf_ra (combinational).
REQ-016 rf_we  output  1  register file write enable.
REQ-017 rf_wa  output  4  register file write address.
REQ-018 rf_wd  output  32  register file write data.
REQ-019 busy  output  1  high in XFER and WB.
REQ-020 done  output  1  one-cycle completion pulse.
REQ-021 count  output  5  registers transferred in current/last operation.
REQ-022 err  output  1  last operation had reglist bit 15 set or an empty effective list; valid from done until next start.

Function
REQ-023 States: IDLE, XFER, WB, DONE; encoding is free.
REQ-024 IDLE + start: latch pend = reglist with bit 15 forced 0, addr = base, load = is_load, count = 0, err = (reglist[15] | pend==0); next XFER if pend != 0, else DONE.
REQ-025 start while not in IDLE is ignored with no effect on any state.
REQ-026 cur = index of lowest set bit of pend (ascending register order); rf_ra = cur, rf_wa = cur in XFER/WB.
REQ-027 XFER, STM: mem_we = 1, mem_addr = addr, mem_wdata = rf_rd; held stable until mem_ack.
REQ-028 STM on mem_ack: clear pend[cur], addr += ADDR_STEP, count += 1; next DONE if pend becomes 0, else remain XFER.
REQ-029 XFER, LDM: mem_re = 1, mem_addr = addr, held until mem_ack; on mem_ack capture mem_rdata into data register, next WB.
REQ-030 WB: rf_we = 1 for exactly one cycle, rf_wd = captured data, rf_wa = cur; clear pend[cur], addr += ADDR_STEP, count += 1; next DONE if pend becomes 0, else XFER.
REQ-031 mem_we, mem_re, rf_we are 0 in every state not listed above; never write R15.
REQ-032 DONE: done = 1 for one cycle, busy = 0; next IDLE; count and err hold until the next accepted start.
REQ-033 Address arithmetic is modulo 2^32; wrap from 0xFFFFFFFC to 0x00000000 is silent.
REQ-034 Zero-wait latency, N registers: STM = N XFER cycles; LDM = 2N cycles (XFER+WB each); DONE follows immediately.
REQ-035 mem_ack outside an active request is ignored.

Reset
REQ-036 rst_n low: state IDLE; busy, done, mem_we, mem_re, rf_we, err = 0; count = 0; mem_addr, rf_ra, rf_wa, rf_wd, pend, data = 0; takes effect immediately regardless of clk.
REQ-037 Reset mid-operation abandons the transfer; no further rf_we or memory request is issued; after release the block waits in IDLE for start.

Verification
REQ-038 STM, reglist=0x0015, base=0x100, ack always 1 -> writes R0@0x100, R2@0x104, R4@0x108 on consecutive cycles, done on 4th cycle, count=3, err=0.
REQ-039 LDM, reglist=0x8003, base=0x200, mem_rdata=0xA0,0xB0 -> rf_we R0=0xA0, R1=0xB0, R15 never written, count=2, err=1.
REQ-040 reglist=0x0000 -> no memory or rf activity, done one cycle after start, count=0, err=1.
REQ-041 STM reglist=0x0001, mem_ack delayed 3 cycles -> mem_we and mem_addr stable 4 cycles, single transfer, done next cycle.
REQ-042 LDM base=0xFFFFFFFC, reglist=0x0003 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-043 rst_n low during second LDM WB of a 4-register list -> outputs zero asynchronously, no further rf_we; start with new list after release runs normally.

Source files
------------

// File: rtl/ldm_stm_seq.sv
// Block load/store-multiple sequencer: walks a 15-entry register mask in
// ascending order, moving one word per register between memory and the register file.
module ldm_stm_seq #(
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reglist,
    input  logic [31:0] base,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  rf_ra,
    input  logic [31:0] rf_rd,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        busy,
    output logic        done,
    output logic [4:0]  count,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [14:0] pend;      // R15 is stripped at start, so it can never be transferred
    logic [31:0] addr;
    logic [31:0] data;
    logic        load;
    logic [3:0]  cur;
    logic [14:0] pend_clr;
    logic [14:0] start_pend;

    function automatic logic [3:0] lowest_set(input logic [14:0] mask);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 14; i >= 0; i--) begin
            if (mask[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // NOTE: every combinational output gets a default assignment first so no latch is inferred.
    always_comb begin
        cur        = 4'd0;
        pend_clr   = 15'd0;
        start_pend = 15'd0;
        cur        = lowest_set(pend);
        // Clearing the lowest set bit is the same as retiring register cur.
        pend_clr   = pend & (pend - 15'd1);
        start_pend = reglist[14:0];
    end

    assign mem_addr  = addr;
    assign mem_wdata = rf_rd;
    assign rf_ra     = cur;
    assign rf_wa     = cur;
    assign rf_wd     = data;

    // NOTE: all state, including the data register, uses non-blocking assignments and a full async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend   <= 15'd0;
            addr   <= 32'd0;
            data   <= 32'd0;
            load   <= 1'b0;
            count  <= 5'd0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            rf_we  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend  <= start_pend;
                        addr  <= base;
                        load  <= is_load;
                        count <= 5'd0;
                        err   <= reglist[15] | (start_pend == 15'd0);
                        if (start_pend != 15'd0) begin
                            state  <= XFER;
                            busy   <= 1'b1;
                            mem_we <= ~is_load;
                            mem_re <= is_load;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                XFER: begin
                    if (mem_ack) begin
                        if (load) begin
                            data   <= mem_rdata;
                            state  <= WB;
                            mem_re <= 1'b0;
                            rf_we  <= 1'b1;
                        end else begin
                            pend  <= pend_clr;
                            addr  <= addr + 32'(ADDR_STEP);
                            count <= count + 5'd1;
                            if (pend_clr == 15'd0) begin
                                state  <= DONE;
                                busy   <= 1'b0;
                                mem_we <= 1'b0;
                                done   <= 1'b1;
                            end
                        end
                    end
                end

                WB: begin
                    rf_we <= 1'b0;
                    pend  <= pend_clr;
                    addr  <= addr + 32'(ADDR_STEP);
                    count <= count + 5'd1;
                    if (pend_clr == 15'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state  <= XFER;
                        mem_re <= 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                    rf_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: a vector table of whole operations plus
// hand-written sequences for stalled ack, ignored start/ack, and mid-operation reset.
module tb_ldm_stm_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic [15:0] reglist;
    logic [31:0] base;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [3:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        busy;
    logic        done;
    logic [4:0]  count;
    logic        err;

    int total = 0;
    int bad   = 0;

    ldm_stm_seq #(.ADDR_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
        .reglist(reglist), .base(base), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy), .done(done),
        .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: each register holds a recognisable constant.
    assign rf_rd = 32'hC0DE_0000 | {28'd0, rf_ra};

    typedef struct {
        logic        is_load;
        logic [15:0] reglist;
        logic [31:0] base;
        int          exp_count;
        logic        exp_err;
        int          exp_done_cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rf_model(input logic [3:0] r);
        return 32'hC0DE_0000 | {28'd0, r};
    endfunction

    function automatic logic [31:0] load_word(input int k);
        return 32'hA0 + 32'(16 * k);
    endfunction

    // Runs one operation with zero-wait ack and checks every transfer and the completion.
    task automatic run_vec(input vec_t v);
        logic [3:0] regs[$];
        int xi;
        int wi;
        int done_cyc;
        xi = 0;
        wi = 0;
        done_cyc = 0;
        for (int i = 0; i < 15; i++) if (v.reglist[i]) regs.push_back(4'(i));

        @(negedge clk);
        start = 1'b1; is_load = v.is_load; reglist = v.reglist; base = v.base;
        mem_ack = 1'b1; mem_rdata = 32'd0;
        @(negedge clk);
        start = 1'b0; reglist = 16'h0; base = 32'h0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            check("busy_active", 32'(busy), 32'd1);
            if (mem_we) begin
                if (xi < regs.size()) begin
                    check("stm_addr", mem_addr, v.base + 32'(4 * xi));
                    check("stm_ra", 32'(rf_ra), 32'(regs[xi]));
                    check("stm_wdata", mem_wdata, rf_model(regs[xi]));
                end
                xi++;
            end
            if (mem_re) begin
                if (xi < regs.size()) begin
                    check("ldm_addr", mem_addr, v.base + 32'(4 * xi));
                    mem_rdata = load_word(xi);
                end
                xi++;
            end
            if (rf_we) begin
                check("rf_wa_not_r15", 32'(rf_wa == 4'd15), 32'd0);
                if (wi < regs.size()) begin
                    check("rf_wa", 32'(rf_wa), 32'(regs[wi]));
                    check("rf_wd", rf_wd, load_word(wi));
                end
                wi++;
            end
        end
        if (done_cyc == 0) check("done_timeout", 32'd1, 32'd0);
        check("done_cycle", 32'(done_cyc), 32'(v.exp_done_cyc));
        check("mem_xfers", 32'(xi), 32'(v.exp_count));
        check("rf_writes", 32'(wi), v.is_load ? 32'(v.exp_count) : 32'd0);
        check("count", 32'(count), 32'(v.exp_count));
        check("err", 32'(err), 32'(v.exp_err));
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_pulse_1cyc", 32'(done), 32'd0);
        check("count_hold", 32'(count), 32'(v.exp_count));
        check("err_hold", 32'(err), 32'(v.exp_err));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 16'h0015, 32'h0000_0100, 3,  1'b0, 4};
        vecs[1] = '{1'b1, 16'h8003, 32'h0000_0200, 2,  1'b1, 5};
        vecs[2] = '{1'b0, 16'h0000, 32'h0000_0500, 0,  1'b1, 1};
        vecs[3] = '{1'b1, 16'h0003, 32'hFFFF_FFFC, 2,  1'b0, 5};
        vecs[4] = '{1'b0, 16'h8000, 32'h0000_0600, 0,  1'b1, 1};
        vecs[5] = '{1'b0, 16'h7FFF, 32'h0000_1000, 15, 1'b0, 16};
        vecs[6] = '{1'b1, 16'h4001, 32'h0000_0020, 2,  1'b0, 5};
        vecs[7] = '{1'b0, 16'hC000, 32'h0000_0000, 1,  1'b1, 2};

        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; reglist = 16'h0;
        base = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'({mem_we, mem_re, rf_we}), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_rf_wd", rf_wd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Stalled STM: request held for 3 wait cycles plus the ack cycle; start during it is ignored.
        @(negedge clk);
        start = 1'b1; is_load = 1'b0; reglist = 16'h0001; base = 32'h0000_0300; mem_ack = 1'b0;
        @(negedge clk);
        reglist = 16'hFFFF; base = 32'h0000_0900; is_load = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("stall_we", 32'(mem_we), 32'd1);
            check("stall_re", 32'(mem_re), 32'd0);
            check("stall_addr", mem_addr, 32'h0000_0300);
            check("stall_wdata", mem_wdata, rf_model(4'd0));
            check("stall_done", 32'(done), 32'd0);
            if (k == 3) start = 1'b0;
            if (k == 4) mem_ack = 1'b1;
            @(negedge clk);
        end
        check("stall_done_next", 32'(done), 32'd1);
        check("stall_we_off", 32'(mem_we), 32'd0);
        check("stall_count", 32'(count), 32'd1);
        check("stall_err", 32'(err), 32'd0);

        // Ack while idle must not move anything.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_ack_busy", 32'(busy), 32'd0);
            check("idle_ack_req", 32'({mem_we, mem_re, rf_we, done}), 32'd0);
            check("idle_ack_count", 32'(count), 32'd1);
        end

        // Reset asserted during the second write-back of a 4-register LDM.
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; reglist = 16'h000F; base = 32'h0000_0400; mem_ack = 1'b1;
        mem_rdata = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        check("rst_seq_xfer0", 32'(mem_re), 32'd1);
        @(negedge clk);
        check("rst_seq_wb0", 32'(rf_we), 32'd1);
        mem_rdata = 32'h2222_2222;
        @(negedge clk);
        check("rst_seq_xfer1", 32'(mem_re), 32'd1);
        check("rst_seq_addr1", mem_addr, 32'h0000_0404);
        @(negedge clk);
        check("rst_seq_wb1_we", 32'(rf_we), 32'd1);
        check("rst_seq_wb1_wa", 32'(rf_wa), 32'd1);
        check("rst_seq_wb1_wd", rf_wd, 32'h2222_2222);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'({mem_we, mem_re, rf_we, busy, done}), 32'd0);
        check("async_rst_addr", mem_addr, 32'd0);
        check("async_rst_wd", rf_wd, 32'd0);
        check("async_rst_wa", 32'({rf_wa, rf_ra}), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({mem_we, mem_re, rf_we, busy, done}), 32'd0);
        end
        run_vec('{1'b0, 16'h0006, 32'h0000_0700, 2, 1'b0, 3});
        run_vec('{1'b1, 16'h0030, 32'h0000_0800, 2, 1'b0, 5});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
